ddr_rd_scheduler_rr: RTL and testbench

- Parametrised successor of the layer-level DDR read scheduler. Serves NUM_CH compute blocks, generalising the fixed two-block case.
- Round-robin arbitration picks one requesting block. The block issues one DDR read burst for it, repacks the 16-bit DDR stream into 18-bit words and delivers them to the granted block.
- Honours per-block one-cycle-ahead pause using an internal elastic FIFO. Sits between the DDR read port and the Block instances of a layer.

---
 rtl/ddr_sched_pkg.sv | 24 ++
 rtl/gearbox_16to18.sv | 54 +++++
 rtl/ddr_rd_scheduler_rr.sv | 160 ++++++++++++++++
 tb/tb_ddr_rd_scheduler_rr.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_sched_pkg.sv
// Shared definitions for the round-robin DDR read scheduler: FSM encoding,
// burst-length helper and configuration sanity check.
package ddr_sched_pkg;

    localparam int WORD18 = 18;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_XFER  = 2'd2,
        ST_DRAIN = 2'd3
    } sched_state_e;

    // 16-bit DDR words needed to carry burst_words 18-bit words.
    function automatic int ddr_len_of(input int burst_words);
        return (burst_words * WORD18) / 16;
    endfunction

    function automatic bit sched_cfg_ok(input int burst_words, input int fifo_depth);
        return (burst_words > 0) && (burst_words % 8 == 0) &&
               (fifo_depth >= burst_words) && ((fifo_depth & (fifo_depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/gearbox_16to18.sv
// Repacks a 16-bit word stream into 18-bit words, MSB-first. The emit is
// combinational with the input beat so the word lands in the FIFO on the same edge.
module gearbox_16to18
    import ddr_sched_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_vld,
    input  logic [15:0]       in_data,
    output logic              out_vld,
    output logic [WORD18-1:0] out_data
);

    logic [33:0] acc_q;
    logic [33:0] acc_cat;
    logic [33:0] acc_d;
    logic [4:0]  cnt_q;
    logic [4:0]  cnt_d;
    logic [5:0]  cnt_sum;

    // Held bits sit left-aligned in acc_q; cnt_q never exceeds 16 between beats.
    always_comb begin
        acc_cat  = acc_q | ({18'd0, in_data} << (5'd18 - cnt_q));
        cnt_sum  = {1'b0, cnt_q} + 6'd16;
        out_vld  = in_vld && (cnt_sum >= 6'd18);
        out_data = acc_cat[33 -: WORD18];
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (in_vld) begin
            if (out_vld) begin
                acc_d = acc_cat << WORD18;
                cnt_d = 5'(cnt_sum - 6'd18);
            end else begin
                acc_d = acc_cat;
                cnt_d = cnt_sum[4:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (clear) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ddr_rd_scheduler_rr.sv
// Round-robin DDR read scheduler: grants one of NUM_CH blocks, issues one burst,
// repacks 16->18 bits and delivers through an elastic FIFO honouring pause-ahead.
module ddr_rd_scheduler_rr
    import ddr_sched_pkg::*;
#(
    parameter int NUM_CH          = 4,
    parameter int WIDTH_ddr_addr  = 25,
    parameter int MAX_WIDTH_Vaddr = 20,
    parameter int BURST_WORDS     = 224,
    parameter int FIFO_DEPTH      = 256,
    parameter logic [NUM_CH*WIDTH_ddr_addr-1:0] BASE_ADDR = '0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_CH-1:0]                 block_req,
    input  logic [NUM_CH*MAX_WIDTH_Vaddr-1:0] flat__block_Vaddr,
    input  logic [NUM_CH-1:0]                 block_pause_ahead1,
    output logic [NUM_CH-1:0]                 block_granted,
    output logic [NUM_CH*WORD18-1:0]          flat__data18bit,
    output logic [NUM_CH-1:0]                 data18bit_vld,
    output logic                              ddr_req,
    output logic [WIDTH_ddr_addr-1:0]         ddr_addr,
    output logic [WIDTH_ddr_addr-1:0]         ddr_len,
    input  logic [15:0]                       ddr_data,
    input  logic                              ddr_en,
    output logic                              err_unexp
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(BURST_WORDS + 1);
    localparam logic [WIDTH_ddr_addr-1:0] DDR_LEN_V = WIDTH_ddr_addr'(ddr_len_of(BURST_WORDS));
    localparam logic [CNT_W-1:0]          BURST_V   = CNT_W'(BURST_WORDS);

    if (NUM_CH < 1 || !sched_cfg_ok(BURST_WORDS, FIFO_DEPTH)) begin : g_cfg_bad
        $error("ddr_rd_scheduler_rr: need NUM_CH>=1, BURST_WORDS%%8==0, FIFO_DEPTH pow2 >= BURST_WORDS");
    end

    sched_state_e              state_q, state_d;
    logic [IDX_W-1:0]          rr_q, idx_q, pick_idx;
    logic                      pick_found;
    int unsigned               cand;
    logic [WIDTH_ddr_addr-1:0] addr_sum, ddr_addr_d;
    logic [WIDTH_ddr_addr-1:0] ddr_cnt_q;
    logic [CNT_W-1:0]          issue_cnt_q;
    logic [NUM_CH-1:0]         grant_vec;
    logic                      accept, fire;
    logic                      gb_vld;
    logic [WORD18-1:0]         gb_data;
    logic [WORD18-1:0]         mem [FIFO_DEPTH];
    logic [AW-1:0]             wr_ptr, rd_ptr;
    logic [AW:0]               fifo_cnt;
    logic                      fifo_empty;
    logic [WORD18-1:0]         data_q;

    assign fifo_empty = (fifo_cnt == '0);

    // First requester at or after the rr pointer, scanning cyclically.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            cand = (int'(rr_q) + k) % NUM_CH;
            if (!pick_found && block_req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end
    end

    // Sum wraps modulo 2^WIDTH_ddr_addr before the bit->word shift.
    always_comb begin
        addr_sum   = BASE_ADDR[int'(pick_idx)*WIDTH_ddr_addr +: WIDTH_ddr_addr] +
                     WIDTH_ddr_addr'(flat__block_Vaddr[int'(pick_idx)*MAX_WIDTH_Vaddr +: MAX_WIDTH_Vaddr]);
        ddr_addr_d = addr_sum >> 4;
    end

    always_comb begin
        state_d = state_q;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            grant_vec[k] = (idx_q == IDX_W'(k));
        end
        case (state_q)
            ST_IDLE:  if (pick_found && fifo_empty) state_d = ST_REQ;
            ST_REQ:   state_d = ST_XFER;
            ST_XFER:  if (ddr_cnt_q == DDR_LEN_V) state_d = ST_DRAIN;
            ST_DRAIN: if (issue_cnt_q == BURST_V) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        ddr_req       = (state_q == ST_REQ);
        block_granted = (state_q != ST_IDLE) ? grant_vec : '0;
        accept        = (state_q == ST_XFER) && ddr_en && (ddr_cnt_q != DDR_LEN_V);
        fire          = ((state_q == ST_XFER) || (state_q == ST_DRAIN)) && !fifo_empty &&
                        !block_pause_ahead1[idx_q] && (issue_cnt_q != BURST_V);
    end

    gearbox_16to18 u_gearbox (
        .clk      (clk),
        .reset    (reset),
        .clear    (state_q == ST_REQ),
        .in_vld   (accept),
        .in_data  (ddr_data),
        .out_vld  (gb_vld),
        .out_data (gb_data)
    );

    always_ff @(posedge clk) begin
        if (gb_vld) mem[wr_ptr] <= gb_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            rr_q          <= '0;
            idx_q         <= '0;
            ddr_addr      <= '0;
            ddr_len       <= '0;
            ddr_cnt_q     <= '0;
            issue_cnt_q   <= '0;
            data18bit_vld <= '0;
            data_q        <= '0;
            err_unexp     <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_cnt      <= '0;
        end else begin
            state_q <= state_d;
            if (ddr_en && state_q != ST_XFER) err_unexp <= 1'b1;
            if (state_q == ST_IDLE && state_d == ST_REQ) begin
                idx_q    <= pick_idx;
                ddr_addr <= ddr_addr_d;
                ddr_len  <= DDR_LEN_V;
            end
            if (state_q == ST_REQ) begin
                ddr_cnt_q   <= '0;
                issue_cnt_q <= '0;
            end else begin
                if (accept) ddr_cnt_q <= ddr_cnt_q + 1'b1;
                if (fire) issue_cnt_q <= issue_cnt_q + 1'b1;
            end
            if (state_q == ST_DRAIN && state_d == ST_IDLE)
                rr_q <= (idx_q == IDX_W'(NUM_CH - 1)) ? '0 : idx_q + 1'b1;
            data18bit_vld <= fire ? grant_vec : '0;
            if (fire) begin
                data_q <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (gb_vld) wr_ptr <= wr_ptr + 1'b1;
            case ({gb_vld, fire})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    assign flat__data18bit = {NUM_CH{data_q}};

endmodule

// File: tb/tb_ddr_rd_scheduler_rr.sv
// Directed bench for ddr_rd_scheduler_rr at NUM_CH=2, BURST_WORDS=8.
module tb_ddr_rd_scheduler_rr;

    localparam int NUM_CH = 2;
    localparam int W      = 25;
    localparam int VW     = 20;
    localparam logic [NUM_CH*W-1:0] BASE = {25'd13824, 25'd0};

    logic                 clk = 1'b0;
    logic                 reset;
    logic [1:0]           block_req, block_pause_ahead1, block_granted, data18bit_vld;
    logic [NUM_CH*VW-1:0] flat__block_Vaddr;
    logic [NUM_CH*18-1:0] flat__data18bit;
    logic                 ddr_req, ddr_en, err_unexp;
    logic [W-1:0]         ddr_addr, ddr_len;
    logic [15:0]          ddr_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ddr_rd_scheduler_rr #(
        .NUM_CH          (NUM_CH),
        .WIDTH_ddr_addr  (W),
        .MAX_WIDTH_Vaddr (VW),
        .BURST_WORDS     (8),
        .FIFO_DEPTH      (16),
        .BASE_ADDR       (BASE)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .block_req          (block_req),
        .flat__block_Vaddr  (flat__block_Vaddr),
        .block_pause_ahead1 (block_pause_ahead1),
        .block_granted      (block_granted),
        .flat__data18bit    (flat__data18bit),
        .data18bit_vld      (data18bit_vld),
        .ddr_req            (ddr_req),
        .ddr_addr           (ddr_addr),
        .ddr_len            (ddr_len),
        .ddr_data           (ddr_data),
        .ddr_en             (ddr_en),
        .err_unexp          (err_unexp)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  req;
        logic        en;
        logic [15:0] d;
        logic        exp_req;
        logic [1:0]  exp_gnt;
        logic [1:0]  exp_vld;
        logic [17:0] exp_data;
    } vec_t;

    vec_t tbl[15];

    // One burst on channel ch: words w0 then wr x8 expected to yield e0 then er x7.
    task automatic run_burst(input int ch, input logic [W-1:0] exp_addr,
                             input logic [15:0] w0, input logic [15:0] wr,
                             input logic [17:0] e0, input logic [17:0] er,
                             input int p_lo, input int p_hi,
                             input logic drop_req, input logic exp_err);
        logic [1:0]  oh;
        logic [1:0]  prev_gnt;
        logic        prev_pause;
        logic [17:0] d;
        bit          seen, done;
        int          cyc, nwords, last_vld;
        oh       = 2'(1 << ch);
        prev_gnt = block_granted;
        seen     = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (ddr_req) seen = 1'b1;
            else prev_gnt = block_granted;
        end
        check("ddr_req_seen", 64'(seen), 64'd1);
        if (!seen) return;
        check("gnt_low_before_req", 64'(prev_gnt), 64'd0);
        check("req_granted", 64'(block_granted), 64'(oh));
        check("req_addr", 64'(ddr_addr), 64'(exp_addr));
        check("req_len", 64'(ddr_len), 64'd9);
        if (drop_req) block_req = 2'b00;
        nwords = 0; last_vld = -1; prev_pause = 1'b0; done = 1'b0; cyc = 1;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (data18bit_vld != 2'b00) begin
                d = flat__data18bit[ch*18 +: 18];
                check("vld_onehot", 64'(data18bit_vld), 64'(oh));
                check("vld_after_pause", 64'(prev_pause), 64'd0);
                check("data_word", 64'(d), 64'((nwords == 0) ? e0 : er));
                check("data_slices_equal", 64'(flat__data18bit[35:18]), 64'(flat__data18bit[17:0]));
                nwords++;
                last_vld = cyc;
            end
            if (block_granted == 2'b00) done = 1'b1;
            ddr_en   = (cyc >= 2 && cyc <= 10);
            ddr_data = (cyc == 2) ? w0 : wr;
            block_pause_ahead1[ch] = (cyc >= p_lo && cyc <= p_hi);
            prev_pause = block_pause_ahead1[ch];
        end
        ddr_en = 1'b0;
        block_pause_ahead1 = 2'b00;
        check("burst_done", 64'(done), 64'd1);
        check("word_count", 64'(nwords), 64'd8);
        check("gnt_drop_after_last", 64'(last_vld), 64'(cyc - 1));
        check("err_unexp", 64'(err_unexp), 64'(exp_err));
    endtask

    initial begin
        reset = 1'b1;
        block_req = 2'b00;
        block_pause_ahead1 = 2'b00;
        flat__block_Vaddr = {20'd4032, 20'd288};
        ddr_en = 1'b0;
        ddr_data = 16'h0000;

        for (int c = 0; c < 15; c++) begin
            tbl[c] = '{req: 2'b00, en: 1'b0, d: 16'h0000, exp_req: 1'b0,
                       exp_gnt: 2'b00, exp_vld: 2'b00, exp_data: 18'h0};
            if (c == 0) tbl[c].req = 2'b10;
            if (c == 1) tbl[c].exp_req = 1'b1;
            if (c >= 1 && c <= 12) tbl[c].exp_gnt = 2'b10;
            if (c >= 2 && c <= 10) begin tbl[c].en = 1'b1; tbl[c].d = 16'hFFFF; end
            if (c >= 5 && c <= 12) begin tbl[c].exp_vld = 2'b10; tbl[c].exp_data = 18'h3FFFF; end
        end

        @(negedge clk);
        check("rst_granted", 64'(block_granted), 64'd0);
        check("rst_vld", 64'(data18bit_vld), 64'd0);
        check("rst_ddr_req", 64'(ddr_req), 64'd0);
        check("rst_data", 64'(flat__data18bit), 64'd0);
        check("rst_len", 64'(ddr_len), 64'd0);
        check("rst_err", 64'(err_unexp), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Single burst for block 1, cycle-exact.
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            check($sformatf("t%0d_ddr_req", c), 64'(ddr_req), 64'(tbl[c].exp_req));
            check($sformatf("t%0d_granted", c), 64'(block_granted), 64'(tbl[c].exp_gnt));
            check($sformatf("t%0d_vld", c), 64'(data18bit_vld), 64'(tbl[c].exp_vld));
            if (tbl[c].exp_vld != 2'b00)
                check($sformatf("t%0d_data", c), 64'(flat__data18bit[35:18]), 64'(tbl[c].exp_data));
            if (tbl[c].exp_req) begin
                check("t_addr", 64'(ddr_addr), 64'd1116);
                check("t_len", 64'(ddr_len), 64'd9);
            end
            block_req = tbl[c].req;
            ddr_en    = tbl[c].en;
            ddr_data  = tbl[c].d;
        end
        check("t_err", 64'(err_unexp), 64'd0);

        // Round robin with both requests held: 0,1,0,1.
        block_req = 2'b11;
        run_burst(0, 25'd18,   16'hAAAA, 16'hAAAA, 18'h2AAAA, 18'h2AAAA, 0, -1, 1'b0, 1'b0);
        run_burst(1, 25'd1116, 16'h5555, 16'h5555, 18'h15555, 18'h15555, 0, -1, 1'b0, 1'b0);
        run_burst(0, 25'd18,   16'hAAAA, 16'hAAAA, 18'h2AAAA, 18'h2AAAA, 0, -1, 1'b0, 1'b0);
        run_burst(1, 25'd1116, 16'h5555, 16'h5555, 18'h15555, 18'h15555, 0, -1, 1'b1, 1'b0);

        // Pause-ahead on block 0 during cycles 3..7 of the burst.
        block_req = 2'b01;
        run_burst(0, 25'd18, 16'hAAAA, 16'hAAAA, 18'h2AAAA, 18'h2AAAA, 3, 7, 1'b1, 1'b0);

        // Bit ordering: MSB of the first DDR word lands at bit 17 of the first output.
        block_req = 2'b10;
        run_burst(1, 25'd1116, 16'h8000, 16'h0000, 18'h20000, 18'h00000, 0, -1, 1'b1, 1'b0);

        // Stray ddr_en while idle.
        @(negedge clk);
        ddr_en = 1'b1; ddr_data = 16'hFFFF;
        @(negedge clk);
        ddr_en = 1'b0;
        check("err_set", 64'(err_unexp), 64'd1);
        repeat (3) @(negedge clk);
        check("err_sticky", 64'(err_unexp), 64'd1);
        check("err_no_vld", 64'(data18bit_vld), 64'd0);
        block_req = 2'b01;
        run_burst(0, 25'd18, 16'hAAAA, 16'hAAAA, 18'h2AAAA, 18'h2AAAA, 0, -1, 1'b1, 1'b1);

        // Reset in the middle of a transfer after 4 DDR words.
        block_req = 2'b10;
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 40 && !seen; i++) begin
                @(negedge clk);
                if (ddr_req) seen = 1'b1;
            end
            check("mid_rst_req_seen", 64'(seen), 64'd1);
        end
        block_req = 2'b00;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            ddr_en = 1'b1; ddr_data = 16'hFFFF;
        end
        @(negedge clk);
        ddr_en = 1'b0;
        reset = 1'b1;
        #1;
        check("mid_rst_granted", 64'(block_granted), 64'd0);
        check("mid_rst_vld", 64'(data18bit_vld), 64'd0);
        check("mid_rst_ddr_req", 64'(ddr_req), 64'd0);
        check("mid_rst_addr", 64'(ddr_addr), 64'd0);
        check("mid_rst_len", 64'(ddr_len), 64'd0);
        check("mid_rst_data", 64'(flat__data18bit), 64'd0);
        check("mid_rst_err", 64'(err_unexp), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            ddr_en = 1'b1; ddr_data = 16'hFFFF;
        end
        @(negedge clk);
        ddr_en = 1'b0;
        check("late_en_err", 64'(err_unexp), 64'd1);
        check("late_en_no_vld", 64'(data18bit_vld), 64'd0);
        block_req = 2'b10;
        run_burst(1, 25'd1116, 16'hFFFF, 16'hFFFF, 18'h3FFFF, 18'h3FFFF, 0, -1, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
